// File: rtl/tile_map_writer_pkg.sv
// Shared VGA tile-map definitions: screen geometry, tile size, grid size
// and the tile type encoding. The tile-map writer imports this package,
// and so do the tile-map readers.
//
// Contents:
//   TILE_PX_DEF / SCREEN_W_DEF / SCREEN_H_DEF : default geometry in pixels
//   GRID_DIM / GRID_BITS                      : 8x8 map, 3 bits per axis
//   COORD_W / MAP_ADDR_W                      : pixel coordinate and map address widths
//   tile_type_t                               : 2-bit tile encoding
//   wr_state_t                                : writer FSM states
//   map_wr_t                                  : one queued map write (address + type)
//   tile_addr()                               : row/col -> linear map address
package tile_map_writer_pkg;

    localparam int TILE_PX_DEF  = 80;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int GRID_DIM     = 8;
    localparam int GRID_BITS    = 3;
    localparam int COORD_W      = 11;
    localparam int MAP_ADDR_W   = 2 * GRID_BITS;

    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'd0,
        TILE_WALL   = 2'd1,
        TILE_ITEM   = 2'd2,
        TILE_HAZARD = 2'd3
    } tile_type_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [MAP_ADDR_W-1:0] addr;
        tile_type_t            kind;
    } map_wr_t;

    // The map is row-major with 8 columns, so row*8+col is a plain bit concatenation.
    function automatic logic [MAP_ADDR_W-1:0] tile_addr(input logic [GRID_BITS-1:0] row,
                                                        input logic [GRID_BITS-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/tile_req_fifo.sv
// Small first-word-fall-through FIFO for pending tile-map writes.
//
// Ports:
//   clk        : clock, rising edge
//   resetN     : asynchronous active-low reset, empties the FIFO
//   flush      : synchronous discard of all entries (wins over push/pop)
//   push       : write push_data when not full
//   push_data  : entry to enqueue
//   pop        : drop the head entry when not empty
//   pop_data   : current head entry (valid while empty=0)
//   full/empty : occupancy flags
module tile_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tile_map_writer.sv
// Tile-map writer: turns pixel-coordinate tile-change requests into writes
// on the 8x8 tile map. Requests are queued and drained only while the
// display is blanked; a clear request sweeps every map cell with one type.
//
// Ports:
//   clk          : clock, rising edge
//   resetN       : asynchronous active-low reset
//   frame_blank  : 1 while outside the active display area (queued writes may drain)
//   req_valid    : tile-change request valid
//   req_ready    : request accepted on an edge where req_valid=1 and req_ready=1
//   req_x/req_y  : pixel coordinate inside the tile to change
//   req_type     : new tile type
//   clear_req    : one-cycle strobe, fill the whole map with clear_type
//   clear_type   : fill type
//   wr_en        : registered map write strobe
//   wr_addr      : registered map address (row*8+col), held when wr_en=0
//   wr_data      : registered tile type, held when wr_en=0
//   busy         : work outstanding (sweep, queued entries or a write on the port)
//   drop_cnt     : saturating count of off-screen requests discarded
module tile_map_writer
    import tile_map_writer_pkg::*;
#(
    parameter int TILE_PX    = TILE_PX_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        frame_blank,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_x,
    input  logic [10:0] req_y,
    input  logic [1:0]  req_type,
    input  logic        clear_req,
    input  logic [1:0]  clear_type,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [1:0]  wr_data,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    wr_state_t              state_reg;
    wr_state_t              state_next;
    logic [MAP_ADDR_W-1:0]  sweep_reg;
    logic [MAP_ADDR_W-1:0]  sweep_next;
    tile_type_t             clear_type_reg;
    tile_type_t             clear_type_next;
    logic                   wr_en_reg;
    logic                   wr_en_next;
    logic [MAP_ADDR_W-1:0]  wr_addr_reg;
    logic [MAP_ADDR_W-1:0]  wr_addr_next;
    tile_type_t             wr_data_reg;
    tile_type_t             wr_data_next;
    logic [7:0]             drop_cnt_reg;
    logic [7:0]             drop_cnt_next;

    logic [GRID_BITS-1:0]   req_col;
    logic [GRID_BITS-1:0]   req_row;
    logic                   req_in_range;
    logic                   req_accept;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    map_wr_t                push_entry;
    map_wr_t                pop_entry;

    // ------------------------------------------------------------------
    // Request acceptance and pixel-to-tile conversion
    // ------------------------------------------------------------------
    // New requests are held off during a sweep and on the clear strobe so
    // nothing can slip into the FIFO in the same cycle it is flushed.
    assign req_ready    = !fifo_full && (state_reg == ST_IDLE) && !clear_req;
    assign req_accept   = req_valid && req_ready;
    assign req_in_range = (req_x < COORD_W'(SCREEN_W)) && (req_y < COORD_W'(SCREEN_H));

    // Division by a constant; only in-range coordinates are ever pushed, so
    // the quotient always fits in 3 bits.
    assign req_col = GRID_BITS'(req_x / COORD_W'(TILE_PX));
    assign req_row = GRID_BITS'(req_y / COORD_W'(TILE_PX));

    assign push_entry.addr = tile_addr(req_row, req_col);
    assign push_entry.kind = tile_type_t'(req_type);
    assign fifo_push       = req_accept && req_in_range;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (req_accept && !req_in_range && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
        end
    end

    tile_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(map_wr_t))
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Writer FSM: next state and registered write port
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        sweep_next      = sweep_reg;
        clear_type_next = clear_type_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;

        if (clear_req) begin
            // Clear overrides everything, including a sweep already running.
            fifo_flush      = 1'b1;
            clear_type_next = tile_type_t'(clear_type);
            sweep_next      = '0;
            state_next      = ST_CLEAR;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    // frame_blank gates the pop directly, so the first
                    // non-blank cycle already stops draining.
                    if (frame_blank && !fifo_empty) begin
                        fifo_pop     = 1'b1;
                        wr_en_next   = 1'b1;
                        wr_addr_next = pop_entry.addr;
                        wr_data_next = pop_entry.kind;
                    end
                end
                ST_CLEAR: begin
                    // The sweep ignores frame_blank: a clear is a full redraw.
                    wr_en_next   = 1'b1;
                    wr_addr_next = sweep_reg;
                    wr_data_next = clear_type_reg;
                    sweep_next   = sweep_reg + 1'b1;
                    if (sweep_reg == MAP_ADDR_W'(GRID_DIM * GRID_DIM - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= ST_IDLE;
            sweep_reg      <= '0;
            clear_type_reg <= TILE_EMPTY;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= TILE_EMPTY;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_reg      <= sweep_next;
            clear_type_reg <= clear_type_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            drop_cnt_reg   <= drop_cnt_next;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign drop_cnt = drop_cnt_reg;

    // A write still presented on the port counts as outstanding work, so
    // busy drops the cycle after the final write of a sweep or a drain.
    assign busy = (state_reg == ST_CLEAR) || !fifo_empty || wr_en_reg;

endmodule

// File: tb/tb_tile_map_writer.sv
module tb_tile_map_writer;

    logic        clk;
    logic        resetN;
    logic        frame_blank;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic [1:0]  req_type;
    logic        clear_req;
    logic [1:0]  clear_type;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0] addr;
        logic [1:0] data;
    } exp_wr_t;

    exp_wr_t sb[$];

    tile_map_writer #(
        .TILE_PX    (80),
        .FIFO_DEPTH (4),
        .SCREEN_W   (640),
        .SCREEN_H   (480)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .frame_blank (frame_blank),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_type    (req_type),
        .clear_req   (clear_req),
        .clear_type  (clear_type),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tile address as the bench understands the map: 80-pixel tiles, row-major, 8 wide.
    function automatic logic [5:0] exp_addr(input int x, input int y);
        return 6'((y / 80) * 8 + (x / 80));
    endfunction

    // Advance one clock and sample 1 time unit later; every write seen on the
    // port must match the oldest scoreboard entry.
    task automatic tick();
        exp_wr_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            $display("write addr=%0d data=%0d t=%0t", wr_addr, wr_data, $time);
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic set_req(input int x, input int y, input int t);
        req_valid = 1'b1;
        req_x     = 11'(x);
        req_y     = 11'(y);
        req_type  = 2'(t);
    endtask

    initial begin
        int xs[5];
        int ys[5];
        int ts[5];

        resetN      = 1'b0;
        frame_blank = 1'b0;
        req_valid   = 1'b0;
        req_x       = '0;
        req_y       = '0;
        req_type    = '0;
        clear_req   = 1'b0;
        clear_type  = '0;

        // ---------------- reset state ----------------
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // ---------------- single request latency ----------------
        frame_blank = 1'b1;
        set_req(170, 250, 2);
        sb.push_back({6'd26, 2'd2});
        check("lat_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("lat_edge1_wr_en", 32'(wr_en), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("lat_edge2_wr_en", 32'(wr_en), 32'd1);
        check("lat_addr26", 32'(wr_addr), 32'd26);
        check("lat_data2", 32'(wr_data), 32'd2);
        tick();
        check("lat_after_wr_en", 32'(wr_en), 32'd0);
        check("lat_hold_addr", 32'(wr_addr), 32'd26);

        // ---------------- fill FIFO while not blanked ----------------
        frame_blank = 1'b0;
        xs = '{0, 639, 80, 559, 300};
        ys = '{0, 479, 80, 160, 300};
        ts = '{1, 3, 2, 0, 1};
        for (int i = 0; i < 5; i++) begin
            set_req(xs[i], ys[i], ts[i]);
            #1;
            check($sformatf("fill_ready_%0d", i), 32'(req_ready), 32'(i < 4));
            if (i < 4) begin
                sb.push_back({exp_addr(xs[i], ys[i]), 2'(ts[i])});
            end
            tick();
        end
        req_valid = 1'b0;
        check("fill_no_write", 32'(wr_en), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        frame_blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_wr_en_%0d", i), 32'(wr_en), 32'd1);
        end
        tick();
        check("drain_done_wr_en", 32'(wr_en), 32'd0);
        check("drain_done_busy", 32'(busy), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);

        // ---------------- off-screen drops ----------------
        set_req(640, 0, 1);
        check("drop_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("drop_x640", 32'(drop_cnt), 32'd1);
        tick();
        check("drop_no_write", 32'(wr_en), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        set_req(0, 480, 2);
        tick();
        req_valid = 1'b0;
        check("drop_y480", 32'(drop_cnt), 32'd2);
        set_req(2000, 2000, 3);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 99) begin
                check("drop_mid", 32'(drop_cnt), 32'd102);
            end
        end
        req_valid = 1'b0;
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        tick();
        check("drop_still_sat", 32'(drop_cnt), 32'd255);

        // ---------------- clear with queued entries ----------------
        frame_blank = 1'b0;
        set_req(160, 0, 1);
        tick();
        set_req(240, 0, 2);
        tick();
        req_valid = 1'b0;
        check("clr_busy_queued", 32'(busy), 32'd1);
        clear_req  = 1'b1;
        clear_type = 2'd1;
        #1;
        check("clr_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 64; i++) begin
            sb.push_back({6'(i), 2'd1});
        end
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            check($sformatf("sweep_wr_en_%0d", i), 32'(wr_en), 32'd1);
            if (i == 63) begin
                check("sweep_last_busy", 32'(busy), 32'd1);
            end
        end
        tick();
        check("sweep_end_wr_en", 32'(wr_en), 32'd0);
        check("sweep_end_busy", 32'(busy), 32'd0);
        check("sweep_sb_empty", 32'(sb.size()), 32'd0);
        frame_blank = 1'b1;
        repeat (4) tick();
        check("flushed_busy", 32'(busy), 32'd0);

        // ---------------- reset during sweep ----------------
        clear_req  = 1'b1;
        clear_type = 2'd3;
        for (int i = 0; i < 20; i++) begin
            sb.push_back({6'(i), 2'd3});
        end
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("pre_rst_addr19", 32'(wr_addr), 32'd19);
        resetN = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        resetN = 1'b1;
        repeat (10) tick();
        check("post_rst_wr_en", 32'(wr_en), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        // ---------------- blank falls between 2nd and 3rd pop ----------------
        frame_blank = 1'b0;
        xs = '{400, 80, 600, 10, 0};
        ys = '{100, 400, 300, 10, 0};
        ts = '{1, 2, 3, 0, 0};
        for (int i = 0; i < 4; i++) begin
            set_req(xs[i], ys[i], ts[i]);
            sb.push_back({exp_addr(xs[i], ys[i]), 2'(ts[i])});
            tick();
        end
        req_valid = 1'b0;
        frame_blank = 1'b1;
        tick();
        check("gap_pop1", 32'(wr_en), 32'd1);
        tick();
        check("gap_pop2", 32'(wr_en), 32'd1);
        frame_blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap_hold_%0d", i), 32'(wr_en), 32'd0);
        end
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_sb_left", 32'(sb.size()), 32'd2);
        frame_blank = 1'b1;
        tick();
        check("gap_pop3", 32'(wr_en), 32'd1);
        tick();
        check("gap_pop4", 32'(wr_en), 32'd1);
        tick();
        check("gap_done", 32'(wr_en), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_map_writer.md
TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port resetN  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port frame_blank  in  1  high while the display is outside the active area; map writes are permitted.
REQ-004 SHALL have ports req_valid  in  1, req_ready  out  1  tile-change request handshake.
REQ-005 SHALL have ports req_x  in  11, req_y  in  11  pixel coordinate of the tile to change.
REQ-006 SHALL have port req_type  in  2  new tile type.
REQ-007 SHALL have ports clear_req  in  1 (one-cycle strobe), clear_type  in  2  whole-map fill request.
REQ-008 SHALL have ports wr_en  out  1, wr_addr  out  6, wr_data  out  2  write port into the 8x8 tile map.
REQ-009 SHALL have ports busy  out  1, drop_cnt  out  8  status.
REQ-010 SHALL have parameters TILE_PX=80, FIFO_DEPTH=4, SCREEN_W=640, SCREEN_H=480.

Function
REQ-011 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-012 SHALL drive req_ready = (FIFO not full) and (state=IDLE) and (clear_req=0).
REQ-013 SHALL convert each accepted request to col=req_x/TILE_PX and row=req_y/TILE_PX (integer, 3 bits each) before pushing it into the FIFO.
REQ-014 SHALL discard a request with req_x>=SCREEN_W or req_y>=SCREEN_H: no push, drop_cnt+1, saturating at 255.
REQ-015 SHALL form wr_addr = row*8+col and wr_data = req_type.
REQ-016 SHALL implement a FIFO of FIFO_DEPTH entries, in-order; a simultaneous push and pop when full is not possible because req_ready=0.
REQ-017 SHALL implement a state machine with states IDLE and CLEAR.
REQ-018 In IDLE, on each edge where frame_blank=1 and the FIFO is non-empty, SHALL pop one entry and register wr_en=1, wr_addr and wr_data from it (one write per cycle).
REQ-019 SHALL register wr_en=0 otherwise; wr_addr and wr_data SHALL hold their last values.
REQ-020 Latency: a request accepted at edge N, with frame_blank=1 and the FIFO empty, SHALL show wr_en=1 after edge N+1.
REQ-021 A frame_blank fall SHALL stop pops immediately; entries wait for the next blank period.
REQ-022 On clear_req=1 in any state, SHALL flush the FIFO, latch clear_type, zero a 6-bit sweep counter and enter CLEAR.
REQ-023 In CLEAR, SHALL write wr_addr=counter and wr_data=latched type every cycle regardless of frame_blank, incrementing the counter; after address 63 it SHALL return to IDLE.
REQ-024 clear_req during CLEAR SHALL restart the sweep from address 0 with the new clear_type.
REQ-025 busy SHALL be 1 when state=CLEAR or the FIFO is non-empty.

Reset
REQ-026 On resetN=0, SHALL immediately set state=IDLE, FIFO empty, wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0 and busy=0; req_ready SHALL follow REQ-012.
REQ-027 Reset during CLEAR SHALL abandon the sweep; no further writes occur.

Structure
REQ-028 SHALL place TILE_PX, the grid size 8, the screen dimensions and the 2-bit tile_type_t enum in the shared VGA package, alongside the tile-map readers.
REQ-029 SHALL implement the FIFO as sub-module tile_req_fifo (parameterised depth and width, with full/empty flags); the FSM and address conversion stay in the top level.

Verification
REQ-030 Bench SHALL check: frame_blank=1, request (x=170, y=250, type=2) -> wr_en after 2 edges, wr_addr=26, wr_data=2.
REQ-031 Bench SHALL check: frame_blank=0, 5 back-to-back requests -> 4 accepted, req_ready=0 on the 5th; raising frame_blank -> 4 writes on consecutive cycles, in order.
REQ-032 Bench SHALL check: request x=640, y=0 -> no write, drop_cnt=1; 300 invalid requests -> drop_cnt=255.
REQ-033 Bench SHALL check: 2 queued entries, then clear_req with clear_type=1 -> FIFO flushed, 64 writes at addr 0..63 with data 1, busy falls one cycle after the last write.
REQ-034 Bench SHALL check: resetN low at sweep address 20 -> wr_en=0 at once, state IDLE, no writes after release.
REQ-035 Bench SHALL check: frame_blank falls between the 2nd and 3rd pops -> 3rd write appears only at the next frame_blank rise.
